// File: rtl/cache_pkg.sv
// Shared cache constants and read-port FSM state type.
// Line layout: valid at the top bit, then tag, then data in the low bits.
package cache_pkg;
  localparam int LINE_W    = 145;
  localparam int VALID_BIT = 144;
  localparam int TAG_HI    = 143;
  localparam int TAG_LO    = 128;
  localparam int DATA_W    = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } state_e;
endpackage

// File: rtl/cache_tag_compare.sv
// Combinational tag match across all ways of one set; zero latency, no flow control.
// Reports a hit and the lowest-numbered matching valid way (0 when nothing matches).
module cache_tag_compare #(
  parameter int WAYS   = 4,
  parameter int TAG_W  = 16,
  parameter int DATA_W = 128,
  localparam int WAY_W = $clog2(WAYS),
  localparam int LW    = 1 + TAG_W + DATA_W
) (
  input  logic [WAYS-1:0][LW-1:0] lines,
  input  logic [TAG_W-1:0]        tag,
  output logic                    hit,
  output logic [WAY_W-1:0]        way
);

  always_comb begin
    hit = 1'b0;
    way = '0;
    // Scan from the top down so the lowest matching way is the last one written.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (lines[w][LW-1] && (lines[w][DATA_W +: TAG_W] == tag)) begin
        hit = 1'b1;
        way = w[WAY_W-1:0];
      end
    end
  end

endmodule

// File: rtl/cache_read_port.sv
// Set-associative line store with a single-outstanding lookup port and hit/miss counters.
// Response appears two cycles after acceptance and is held until resp_ready; fills accepted every cycle.
module cache_read_port #(
  parameter int WAYS   = 4,
  parameter int SETS   = 16,
  parameter int TAG_W  = 16,
  parameter int DATA_W = 128,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = $clog2(WAYS),
  localparam int LW    = 1 + TAG_W + DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill_en,
  input  logic [IDX_W-1:0]  fill_index,
  input  logic [WAY_W-1:0]  fill_way,
  input  logic [LW-1:0]     fill_line,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IDX_W-1:0]  req_index,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_hit,
  output logic [WAY_W-1:0]  resp_way,
  output logic [DATA_W-1:0] resp_data,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);
  import cache_pkg::*;

  state_e state_q, state_d;
  logic [SETS-1:0][WAYS-1:0][LW-1:0] mem_q, mem_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              resp_hit_q, resp_hit_d;
  logic [WAY_W-1:0]  resp_way_q, resp_way_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic [15:0]       hit_count_q, hit_count_d;
  logic [15:0]       miss_count_q, miss_count_d;

  logic [WAYS-1:0][LW-1:0] set_lines;
  logic                    cmp_hit;
  logic [WAY_W-1:0]        cmp_way;

  // Lookup reads the pre-fill array, so a same-cycle fill only shows up later.
  assign set_lines = mem_q[idx_q];

  cache_tag_compare #(
    .WAYS   (WAYS),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_cmp (
    .lines (set_lines),
    .tag   (tag_q),
    .hit   (cmp_hit),
    .way   (cmp_way)
  );

  always_comb begin
    state_d      = state_q;
    mem_d        = mem_q;
    idx_d        = idx_q;
    tag_d        = tag_q;
    resp_hit_d   = resp_hit_q;
    resp_way_d   = resp_way_q;
    resp_data_d  = resp_data_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;

    if (fill_en) begin
      mem_d[fill_index][fill_way] = fill_line;
    end

    case (state_q)
      IDLE: begin
        req_ready = !rst;
        if (req_valid) begin
          idx_d   = req_index;
          tag_d   = req_tag;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        resp_hit_d  = cmp_hit;
        resp_way_d  = cmp_hit ? cmp_way : '0;
        resp_data_d = cmp_hit ? set_lines[cmp_way][DATA_W-1:0] : '0;
        if (cmp_hit) begin
          if (hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
        end else begin
          if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
        end
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      tag_q        <= '0;
      resp_hit_q   <= 1'b0;
      resp_way_q   <= '0;
      resp_data_q  <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          mem_q[s][w][LW-1] <= 1'b0;
        end
      end
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      idx_q        <= idx_d;
      tag_q        <= tag_d;
      resp_hit_q   <= resp_hit_d;
      resp_way_q   <= resp_way_d;
      resp_data_q  <= resp_data_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign resp_hit   = resp_hit_q;
  assign resp_way   = resp_way_q;
  assign resp_data  = resp_data_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_cache_read_port.sv
// Bench for cache_read_port: fixed vectors, hand sequences for hold/same-cycle fill/saturation/reset,
// then random fills and lookups against an array-based reference of the cache contents.
module tb_cache_read_port;
  import cache_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fill_en = 1'b0;
  logic [3:0]   fill_index = '0;
  logic [1:0]   fill_way = '0;
  logic [144:0] fill_line = '0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [3:0]   req_index = '0;
  logic [15:0]  req_tag = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic         resp_hit;
  logic [1:0]   resp_way;
  logic [127:0] resp_data;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [144:0] model_mem [16][4];
  logic [15:0]  model_hits;
  logic [15:0]  model_misses;

  typedef struct {
    bit           fe;
    logic [3:0]   fidx;
    logic [1:0]   fway;
    logic [144:0] fline;
    logic [3:0]   ridx;
    logic [15:0]  rtag;
    bit           ehit;
    logic [1:0]   eway;
    logic [127:0] edata;
  } vec_t;

  vec_t tbl[$];

  cache_read_port dut (
    .clk        (clk),
    .rst        (rst),
    .fill_en    (fill_en),
    .fill_index (fill_index),
    .fill_way   (fill_way),
    .fill_line  (fill_line),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_index  (req_index),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_hit   (resp_hit),
    .resp_way   (resp_way),
    .resp_data  (resp_data),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  function automatic void model_find(input logic [3:0] idx, input logic [15:0] tag,
                                     output bit h, output logic [1:0] w, output logic [127:0] d);
    h = 1'b0; w = '0; d = '0;
    for (int i = 0; i < 4; i++) begin
      if (!h && model_mem[idx][i][VALID_BIT] === 1'b1 && model_mem[idx][i][TAG_HI:TAG_LO] == tag) begin
        h = 1'b1;
        w = i[1:0];
        d = model_mem[idx][i][DATA_W-1:0];
      end
    end
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 4; w++)
        model_mem[s][w][VALID_BIT] = 1'b0;
    model_hits = '0;
    model_misses = '0;
  endfunction

  task automatic do_fill(input logic [3:0] idx, input logic [1:0] way, input logic [144:0] line);
    @(negedge clk);
    fill_en = 1'b1; fill_index = idx; fill_way = way; fill_line = line;
    @(posedge clk); #1;
    fill_en = 1'b0;
    model_mem[idx][way] = line;
  endtask

  // Issues one lookup, checks the two-cycle latency and the held response against expectations.
  task automatic lookup(input string nm, input logic [3:0] idx, input logic [15:0] tag,
                        input bit eh, input logic [1:0] ew, input logic [127:0] ed,
                        input int hold, input bit fill_lk, input bit fill_hold,
                        input logic [1:0] fway, input logic [144:0] fline);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_index = idx; req_tag = tag;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " accept"}, {127'd0, req_ready}, 128'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_index = 4'($urandom);
    req_tag = 16'($urandom);
    if (fill_lk) begin
      fill_en = 1'b1; fill_index = idx; fill_way = fway; fill_line = fline;
    end
    @(negedge clk);
    chk({nm, " early_valid"}, {127'd0, resp_valid}, 128'd0);
    chk({nm, " busy_ready"}, {127'd0, req_ready}, 128'd0);
    @(posedge clk); #1;
    if (fill_lk) begin
      fill_en = 1'b0;
      model_mem[idx][fway] = fline;
    end
    if (eh) begin
      if (model_hits != 16'hFFFF) model_hits++;
    end else begin
      if (model_misses != 16'hFFFF) model_misses++;
    end
    @(negedge clk);
    chk({nm, " valid"}, {127'd0, resp_valid}, 128'd1);
    chk({nm, " hit"}, {127'd0, resp_hit}, {127'd0, eh});
    chk({nm, " way"}, {126'd0, resp_way}, {126'd0, ew});
    chk({nm, " data"}, resp_data, ed);
    chk({nm, " hit_count"}, {112'd0, hit_count}, {112'd0, model_hits});
    chk({nm, " miss_count"}, {112'd0, miss_count}, {112'd0, model_misses});
    for (int i = 0; i < hold; i++) begin
      if (fill_hold && i == 1) begin
        fill_en = 1'b1; fill_index = idx; fill_way = fway; fill_line = fline;
      end
      @(posedge clk); #1;
      if (fill_en) begin
        fill_en = 1'b0;
        model_mem[idx][fway] = fline;
      end
      @(negedge clk);
      chk($sformatf("%s hold%0d valid", nm, i), {127'd0, resp_valid}, 128'd1);
      chk($sformatf("%s hold%0d ready", nm, i), {127'd0, req_ready}, 128'd0);
      chk($sformatf("%s hold%0d hit", nm, i), {127'd0, resp_hit}, {127'd0, eh});
      chk($sformatf("%s hold%0d way", nm, i), {126'd0, resp_way}, {126'd0, ew});
      chk($sformatf("%s hold%0d data", nm, i), resp_data, ed);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic model_lookup(input string nm, input logic [3:0] idx, input logic [15:0] tag,
                              input int hold, input bit fill_lk, input bit fill_hold,
                              input logic [1:0] fway, input logic [144:0] fline);
    bit h; logic [1:0] w; logic [127:0] d;
    model_find(idx, tag, h, w, d);
    lookup(nm, idx, tag, h, w, d, hold, fill_lk, fill_hold, fway, fline);
  endtask

  initial begin
    // Reset with a fill presented that must be discarded.
    rst = 1'b1;
    fill_en = 1'b1; fill_index = 4'd2; fill_way = 2'd0; fill_line = {1'b1, 16'hBEEF, 128'h5};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst req_ready", {127'd0, req_ready}, 128'd0);
    chk("rst resp_valid", {127'd0, resp_valid}, 128'd0);
    chk("rst hit_count", {112'd0, hit_count}, 128'd0);
    chk("rst miss_count", {112'd0, miss_count}, 128'd0);
    chk("rst resp_data", resp_data, 128'd0);
    fill_en = 1'b0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("post_rst req_ready", {127'd0, req_ready}, 128'd1);

    tbl.push_back('{1'b0, 4'd0, 2'd0, 145'd0, 4'd3, 16'h1234, 1'b0, 2'd0, 128'd0});
    tbl.push_back('{1'b1, 4'd5, 2'd2, {1'b1, 16'hABCD, 128'hDEAD_BEEF}, 4'd5, 16'hABCD, 1'b1, 2'd2, 128'hDEAD_BEEF});
    tbl.push_back('{1'b1, 4'd7, 2'd3, {1'b1, 16'h5555, 128'h333}, 4'd7, 16'h5555, 1'b1, 2'd3, 128'h333});
    tbl.push_back('{1'b1, 4'd7, 2'd1, {1'b1, 16'h5555, 128'h111}, 4'd7, 16'h5555, 1'b1, 2'd1, 128'h111});
    tbl.push_back('{1'b0, 4'd0, 2'd0, 145'd0, 4'd2, 16'hBEEF, 1'b0, 2'd0, 128'd0});
    tbl.push_back('{1'b1, 4'd9, 2'd0, {1'b0, 16'h7777, 128'h999}, 4'd9, 16'h7777, 1'b0, 2'd0, 128'd0});
    tbl.push_back('{1'b0, 4'd0, 2'd0, 145'd0, 4'd5, 16'hABCE, 1'b0, 2'd0, 128'd0});
    tbl.push_back('{1'b1, 4'd15, 2'd3, {1'b1, 16'hFFFF, {128{1'b1}}}, 4'd15, 16'hFFFF, 1'b1, 2'd3, {128{1'b1}}});
    tbl.push_back('{1'b1, 4'd0, 2'd0, {1'b1, 16'h0000, 128'h42}, 4'd0, 16'h0000, 1'b1, 2'd0, 128'h42});

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].fe) do_fill(tbl[i].fidx, tbl[i].fway, tbl[i].fline);
      lookup($sformatf("vec%0d", i), tbl[i].ridx, tbl[i].rtag, tbl[i].ehit, tbl[i].eway,
             tbl[i].edata, 0, 1'b0, 1'b0, 2'd0, 145'd0);
    end

    // Backpressure for five cycles with an overwrite of the same line mid-hold.
    lookup("hold", 4'd5, 16'hABCD, 1'b1, 2'd2, 128'hDEAD_BEEF, 5, 1'b0, 1'b1,
           2'd2, {1'b1, 16'hABCD, 128'h1111});
    lookup("after_hold", 4'd5, 16'hABCD, 1'b1, 2'd2, 128'h1111, 0, 1'b0, 1'b0, 2'd0, 145'd0);

    // Fill landing in the LOOKUP cycle is invisible to that lookup, visible to the next.
    lookup("samecyc", 4'd11, 16'hCAFE, 1'b0, 2'd0, 128'd0, 0, 1'b1, 1'b0,
           2'd1, {1'b1, 16'hCAFE, 128'h77});
    lookup("samecyc_again", 4'd11, 16'hCAFE, 1'b1, 2'd1, 128'h77, 0, 1'b0, 1'b0, 2'd0, 145'd0);

    // Counter saturation.
    @(negedge clk);
    force dut.hit_count_q = 16'hFFFC;
    @(posedge clk); #1;
    release dut.hit_count_q;
    model_hits = 16'hFFFC;
    for (int i = 0; i < 2; i++)
      lookup($sformatf("pre%0d", i), 4'd0, 16'h0000, 1'b1, 2'd0, 128'h42, 0, 1'b0, 1'b0, 2'd0, 145'd0);
    chk("preload", {112'd0, hit_count}, {112'd0, 16'hFFFE});
    for (int i = 0; i < 3; i++)
      lookup($sformatf("sat%0d", i), 4'd0, 16'h0000, 1'b1, 2'd0, 128'h42, 0, 1'b0, 1'b0, 2'd0, 145'd0);
    chk("saturated", {112'd0, hit_count}, {112'd0, 16'hFFFF});

    // Reset while a response is being held.
    @(negedge clk);
    req_valid = 1'b1; req_index = 4'd0; req_tag = 16'h0000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_resp pre_valid", {127'd0, resp_valid}, 128'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_resp valid", {127'd0, resp_valid}, 128'd0);
    chk("rst_resp hit_count", {112'd0, hit_count}, 128'd0);
    chk("rst_resp miss_count", {112'd0, miss_count}, 128'd0);
    chk("rst_resp resp_hit", {127'd0, resp_hit}, 128'd0);
    chk("rst_resp resp_data", resp_data, 128'd0);
    chk("rst_resp req_ready", {127'd0, req_ready}, 128'd1);
    lookup("rst_invalidated", 4'd0, 16'h0000, 1'b0, 2'd0, 128'd0, 0, 1'b0, 1'b0, 2'd0, 145'd0);

    // Random fills and lookups on a small index/tag space so hits and multi-way matches occur.
    for (int it = 0; it < 60; it++) begin
      logic [144:0] ln;
      logic [3:0]   ri;
      ri = 4'($urandom_range(0, 3));
      ln = {($urandom_range(0, 4) != 0), 16'($urandom_range(0, 3)),
            32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 1) == 1)
        do_fill(4'($urandom_range(0, 3)), 2'($urandom), ln);
      model_lookup($sformatf("rnd%0d", it), ri, 16'($urandom_range(0, 3)),
                   $urandom_range(0, 2), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                   2'($urandom), {1'b1, 16'($urandom_range(0, 3)), 96'd0, 32'($urandom)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
